ll_pop_scheduler: RTL
=====================

# ll_pop_scheduler

Dequeue controller for the shared linked-list FIFO. Watches the per-queue `empty` flags of the `NUM_FIFOS` logical queues, chooses which queue to pop each cycle using round-robin with a per-queue burst quantum, and drives the shared FIFO's `pop`/`pop_sel`. It captures the popped word into a one-entry output register that has a valid/ready handshake toward the downstream consumer. The block sits between the shared FIFO's read side and a single downstream sink.

## Interface
- `WIDTH`, 8, data word width; must match the shared FIFO.
- `NUM_FIFOS`, 2, number of logical queues; must be ≥ 2.
- `BURST`, 2, maximum consecutive pops granted to one queue before rotating; must be ≥ 1.
- `SEL_WIDTH`, `$clog2(NUM_FIFOS)`, width of queue selectors.
- `CNT_WIDTH`, `$clog2(BURST+1)`, width of the burst counter.

- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `q_empty`  in  NUM_FIFOS  shared FIFO `empty` vector.
- `q_en`  in  NUM_FIFOS  per-queue service enable; a masked queue is never granted.
- `fifo_data`  in  WIDTH  shared FIFO `data_out`; head of queue `pop_sel`, valid combinationally in the same cycle.
- `pop`  out  1  pop strobe to the shared FIFO.
- `pop_sel`  out  SEL_WIDTH  queue popped when `pop`=1.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  downstream accepts the word when `out_valid & out_ready`.
- `out_data`  out  WIDTH  registered popped word.
- `out_qid`  out  SEL_WIDTH  source queue of `out_data`.

## Operation
- FSM states: `ARB` (no current grant) and `SERVE` (holding grant `cur_q` with burst count `bcnt`).
- `slot_free = ~out_valid | out_ready`. No pop is issued unless `slot_free` is 1.
- Eligible vector: `elig = ~q_empty & q_en`.
- `ARB`: if `slot_free` and `elig`≠0, grant the first eligible queue strictly after `rr_ptr` (modulo `NUM_FIFOS`). Issue `pop`=1 with `pop_sel`=grant in the same cycle. Set `cur_q`=grant and `bcnt`=1, then go to `SERVE`, or stay in `ARB` if `BURST`==1. Set `rr_ptr`=grant.
- `SERVE`: if `elig[cur_q]` and `slot_free`, pop `cur_q` and increment `bcnt`; on reaching `BURST`, go to `ARB`.
  - If `~elig[cur_q]` (queue emptied or masked), go to `ARB` with no pop this cycle.
  - If `~slot_free`, hold state and do not pop.
- On any pop, the output register loads `fifo_data` and `pop_sel` next edge and `out_valid`=1. Otherwise, if `out_ready`, `out_valid`→0.
- `pop_sel` drives 0 whenever `pop`=0.
- Invariant: `pop` ⇒ `~q_empty[pop_sel] & q_en[pop_sel]`. Never pop an empty queue.
- At most one pop per cycle. Throughput is one word per cycle while the sink holds `out_ready`=1.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_qid`=0, `pop`=0, `pop_sel`=0; FSM=`ARB`, `rr_ptr`=`NUM_FIFOS-1` (so queue 0 wins first), `bcnt`=0.
- `pop` and `pop_sel` are combinational from state and inputs in cycle t. The word appears on `out_data` in t+1 with `out_valid`=1.
- Simultaneous drain and pop in the same cycle: the register is replaced and `out_valid` stays 1.
- `rst` asserted mid-burst forces `pop`=0 that cycle and clears all state at the edge. The word held in the output register is discarded.
- `bcnt` saturates at `BURST` and never wraps.

## Configuration
- `LL_SCHED_PRIO0_EN`: when defined, queue 0 is strict priority. In `ARB` and at every `SERVE` cycle, if `elig[0]` and `slot_free`, queue 0 is popped and preempts the current grant. `cur_q` becomes 0 and `rr_ptr` is unchanged.
- When undefined, all queues are pure round-robin with burst quantum as above.

## Structure
- Package `ll_sched_pkg` holds:
  - the FSM state enum (`ARB`, `SERVE`);
  - helper function `rr_next(elig, ptr)`.
- Sub-module `rr_arbiter` (parameters `N`, `SEL_WIDTH`): combinational round-robin pick.
  - Inputs `req[N]`, `ptr`; outputs `gnt_vld`, `gnt_idx`.
  - Instantiated once. The FSM, burst counter and output register live in `ll_pop_scheduler`.

## Test plan
- Reset with all queues non-empty, `out_ready`=1, `BURST`=2 → pops in order q0,q0,q1,q1,q0… Each word appears one cycle later with matching `out_qid`.
- Queue 1 holds one word, q0 empty → a single pop of q1, then `pop`=0 and FSM returns to `ARB` with `bcnt` reset.
- `out_ready`=0 for 3 cycles with a word held → `pop`=0 and `out_data` stable. On `out_ready`=1, the same-cycle pop refills the register and `out_valid` stays 1.
- `q_en[1]`=0 with q1 non-empty → q1 is never selected. Deasserting `q_en[0]` mid-burst ends the grant with no pop that cycle.
- Assert `rst` in the cycle after a pop → `out_valid`=0 next edge and the first post-reset grant is q0.
- With `LL_SCHED_PRIO0_EN` defined: q1 mid-burst and q0 becoming non-empty → q0 is popped that cycle and on every following cycle until it empties.

Source files
------------

// File: rtl/ll_pop_scheduler_pkg.sv
// ll_sched_pkg
//   Shared types and helpers for the linked-list pop scheduler.
//   - sched_state_e : scheduler FSM state (ARB = no grant, SERVE = holding a grant)
//   - rr_pick_t     : result of a round-robin search (valid flag + index)
//   - rr_next()     : first eligible queue strictly after a pointer, wrapping
//                     modulo the number of queues actually in use.
package ll_sched_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    SERVE = 1'b1
  } sched_state_e;

  // The search helper works on a fixed-size request vector so it can be
  // shared by any arbiter instance; callers zero-pad unused request bits.
  localparam int unsigned RR_MAX_Q = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef struct packed {
    logic                vld;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Scans ptr+1, ptr+2, ... (mod n) and returns the first set bit of elig.
  // ptr must be < n; bits of elig at or above n must be zero.
  function automatic rr_pick_t rr_next(input logic [RR_MAX_Q-1:0] elig,
                                       input int unsigned         ptr,
                                       input int unsigned         n);
    rr_pick_t    pick;
    int unsigned cand;
    pick = '0;
    for (int unsigned k = 1; k <= RR_MAX_Q; k++) begin
      cand = ptr + k;
      if (cand >= n) cand = cand - n;
      if ((k <= n) && !pick.vld && elig[cand[RR_IDX_W-1:0]]) begin
        pick.vld = 1'b1;
        pick.idx = cand[RR_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ll_pop_scheduler_if.sv
// ll_pop_scheduler_if
//   Bundles the shared-FIFO read side and the downstream output port of the
//   pop scheduler.
//   Ports carried:
//     q_empty   [NUM_FIFOS]  per-queue empty flags from the shared FIFO
//     q_en      [NUM_FIFOS]  per-queue service enable
//     fifo_data [WIDTH]      head word of queue pop_sel (combinational)
//     pop                    pop strobe toward the shared FIFO
//     pop_sel   [SEL_WIDTH]  queue being popped (0 when pop = 0)
//     out_valid/out_ready    output handshake
//     out_data  [WIDTH]      registered popped word
//     out_qid   [SEL_WIDTH]  source queue of out_data
//   Modports: master = scheduler side, slave = FIFO + downstream sink side.
//
//   Handshake: a word moves downstream on every rising clock edge where
//   out_valid and out_ready are both 1. out_valid, out_data and out_qid do not
//   change while out_valid = 1 and out_ready = 0. out_ready may be driven
//   independently of out_valid.
interface ll_pop_scheduler_if #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
);
  logic [NUM_FIFOS-1:0] q_empty;
  logic [NUM_FIFOS-1:0] q_en;
  logic [WIDTH-1:0]     fifo_data;
  logic                 pop;
  logic [SEL_WIDTH-1:0] pop_sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_qid;

  modport master (
    input  q_empty, q_en, fifo_data, out_ready,
    output pop, pop_sel, out_valid, out_data, out_qid
  );

  modport slave (
    output q_empty, q_en, fifo_data, out_ready,
    input  pop, pop_sel, out_valid, out_data, out_qid
  );
endinterface

// File: rtl/ll_pop_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: grants the first requesting index
//   strictly after ptr, wrapping modulo N.
//   Ports:
//     req     [N]          request vector
//     ptr     [SEL_WIDTH]  last granted index (search starts at ptr+1)
//     gnt_vld              at least one request present
//     gnt_idx [SEL_WIDTH]  granted index (0 when gnt_vld = 0)
//   N is limited to ll_sched_pkg::RR_MAX_Q.
module rr_arbiter
  import ll_sched_pkg::*;
#(
  parameter int N         = 2,
  parameter int SEL_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]         req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 gnt_vld,
  output logic [SEL_WIDTH-1:0] gnt_idx
);

  logic [RR_MAX_Q-1:0] w_req_pad;
  rr_pick_t            w_pick;

  always_comb begin
    w_req_pad        = '0;
    w_req_pad[N-1:0] = req;
  end

  assign w_pick  = rr_next(w_req_pad, 32'(ptr), N);
  assign gnt_vld = w_pick.vld;
  assign gnt_idx = SEL_WIDTH'(w_pick.idx);

endmodule

// File: rtl/ll_pop_scheduler.sv
// ll_pop_scheduler
//   Dequeue controller for the shared linked-list FIFO. Picks one logical
//   queue per cycle (round-robin with a burst quantum of BURST pops), drives
//   pop/pop_sel combinationally, and captures the popped word into a
//   one-entry output register with a valid/ready handshake.
//   Ports:
//     clk, rst       clock; synchronous active-high reset
//     bus            ll_pop_scheduler_if.master (FIFO read side + output port)
//     o_dbg_state    current FSM state
//     o_dbg_bcnt     pops granted to the current queue in this burst
//     o_dbg_cur_q    currently granted queue
//     o_dbg_rr_ptr   last queue granted by round-robin arbitration
//   Build option:
//     LL_SCHED_PRIO0_EN  queue 0 becomes strict priority and preempts any
//                        grant whenever it is eligible and the slot is free.
module ll_pop_scheduler
  import ll_sched_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int BURST     = 2,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
  parameter int CNT_WIDTH = $clog2(BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  ll_pop_scheduler_if.master   bus,
  output sched_state_e         o_dbg_state,
  output logic [CNT_WIDTH-1:0] o_dbg_bcnt,
  output logic [SEL_WIDTH-1:0] o_dbg_cur_q,
  output logic [SEL_WIDTH-1:0] o_dbg_rr_ptr
);

  localparam logic [CNT_WIDTH-1:0] BURST_C = CNT_WIDTH'(BURST);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] LAST_Q  = SEL_WIDTH'(NUM_FIFOS - 1);
  // A single-pop quantum never needs the SERVE state.
  localparam sched_state_e AFTER_GRANT = (BURST == 1) ? ARB : SERVE;

  sched_state_e         r_state;
  logic [SEL_WIDTH-1:0] r_cur_q;
  logic [CNT_WIDTH-1:0] r_bcnt;
  logic [SEL_WIDTH-1:0] r_rr_ptr;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_data;
  logic [SEL_WIDTH-1:0] r_out_qid;

  logic [NUM_FIFOS-1:0] w_elig;
  logic                 w_slot_free;
  logic                 w_gnt_vld;
  logic [SEL_WIDTH-1:0] w_gnt_idx;
  logic                 w_cur_elig;
  logic                 w_prio_pop;
  logic                 w_new_grant;
  logic                 w_pop;
  logic [SEL_WIDTH-1:0] w_pop_sel;
  logic [CNT_WIDTH-1:0] w_bcnt_inc;

  assign w_elig      = ~bus.q_empty & bus.q_en;
  // The output register can take a new word if it is empty or draining now.
  assign w_slot_free = ~r_out_valid | bus.out_ready;
  assign w_cur_elig  = w_elig[r_cur_q];
  assign w_bcnt_inc  = (r_bcnt >= BURST_C) ? BURST_C : r_bcnt + ONE_C;

  rr_arbiter #(
    .N         (NUM_FIFOS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_arbiter (
    .req     (w_elig),
    .ptr     (r_rr_ptr),
    .gnt_vld (w_gnt_vld),
    .gnt_idx (w_gnt_idx)
  );

`ifdef LL_SCHED_PRIO0_EN
  assign w_prio_pop = ~rst & w_slot_free & w_elig[0];
`else
  assign w_prio_pop = 1'b0;
`endif

  // Pop decision. rst gates everything so a burst in flight stops the
  // same cycle reset is asserted.
  always_comb begin
    w_pop       = 1'b0;
    w_pop_sel   = '0;
    w_new_grant = 1'b0;
    if (w_prio_pop) begin
      w_pop = 1'b1;
    end else if (!rst && w_slot_free) begin
      if (r_state == ARB) begin
        if (w_gnt_vld) begin
          w_pop       = 1'b1;
          w_pop_sel   = w_gnt_idx;
          w_new_grant = 1'b1;
        end
      end else if (w_cur_elig) begin
        w_pop     = 1'b1;
        w_pop_sel = r_cur_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB;
      r_cur_q     <= '0;
      r_bcnt      <= '0;
      r_rr_ptr    <= LAST_Q;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_qid   <= '0;
    end else begin
      // Output register: a pop always overwrites it (the old word is
      // draining in the same cycle because the slot was free).
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.fifo_data;
        r_out_qid   <= w_pop_sel;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_prio_pop) begin
        // Queue 0 takes over the grant; the round-robin pointer is left
        // alone so the other queues resume where they were.
        r_cur_q <= '0;
        if (r_state == SERVE && r_cur_q == '0) begin
          r_bcnt  <= w_bcnt_inc;
          r_state <= (w_bcnt_inc == BURST_C) ? ARB : SERVE;
        end else begin
          r_bcnt  <= ONE_C;
          r_state <= AFTER_GRANT;
        end
      end else begin
        case (r_state)
          ARB: begin
            if (w_new_grant) begin
              r_cur_q  <= w_gnt_idx;
              r_rr_ptr <= w_gnt_idx;
              r_bcnt   <= ONE_C;
              r_state  <= AFTER_GRANT;
            end
          end
          SERVE: begin
            if (!w_cur_elig) begin
              // Queue emptied or was masked: give up the grant, no pop.
              r_state <= ARB;
              r_bcnt  <= '0;
            end else if (w_slot_free) begin
              r_bcnt <= w_bcnt_inc;
              if (w_bcnt_inc == BURST_C) r_state <= ARB;
            end
          end
          default: r_state <= ARB;
        endcase
      end
    end
  end

  assign bus.pop       = w_pop;
  assign bus.pop_sel   = w_pop_sel;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_qid   = r_out_qid;

  assign o_dbg_state  = r_state;
  assign o_dbg_bcnt   = r_bcnt;
  assign o_dbg_cur_q  = r_cur_q;
  assign o_dbg_rr_ptr = r_rr_ptr;

endmodule
